// File: rtl/nibble_serial_addsub.sv
// Digit-serial adder/subtractor: one N-bit add slice reused WORDS times,
// LSB slice first, producing a W = N*WORDS bit sum or difference with flags.
module nibble_serial_addsub #(
    parameter int unsigned N     = 4,
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 op,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   result,
    output logic                 carry_out,
    output logic                 overflow,
    output logic                 zero
);

    localparam int unsigned W  = N * WORDS;
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            op_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic [W-1:0]    result_q;
    logic            busy_q;
    logic            done_q;
    logic            carry_out_q;
    logic            overflow_q;
    logic            zero_q;

    logic [N-1:0]    x_c;
    logic [N-1:0]    y_c;
    logic [N-1:0]    yk_c;
    logic [N-1:0]    s_c;
    logic            cu_c;
    logic            last_c;
    logic [W-1:0]    result_d;

    // The single shared slice; subtract is a + ~b with the carry seeded by op.
    always_comb begin
        x_c             = a_q[idx_q*N +: N];
        y_c             = b_q[idx_q*N +: N];
        yk_c            = op_q ? ~y_c : y_c;
        {cu_c, s_c}     = (N+1)'(x_c) + (N+1)'(yk_c) + (N+1)'(carry_q);
        result_d        = result_q;
        result_d[idx_q*N +: N] = s_c;
        last_c          = (idx_q == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        idx_q   <= '0;
                        carry_q <= op;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    carry_q  <= cu_c;
                    idx_q    <= idx_q + 1'b1;
                    // Flags are only committed once the top slice is known.
                    if (last_c) begin
                        carry_out_q <= cu_c;
                        overflow_q  <= (a_q[W-1] == yk_c[N-1]) && (s_c[N-1] != a_q[W-1]);
                        zero_q      <= (result_d == '0);
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: doc/nibble_serial_addsub.md
NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

Interface
REQ-001 Parameter N, default 4: width of the single add/sub slice in bits.
REQ-002 Parameter WORDS, default 4: number of slices per operand; operand width W = N*WORDS, 16 by default.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port start, input, 1: request to begin an operation; sampled only in IDLE.
REQ-006 Port op, input, 1: operation select; 0 = a+b, 1 = a-b.
REQ-007 Port a, input, W: first operand.
REQ-008 Port b, input, W: second operand.
REQ-009 Port busy, output, 1: operation in progress.
REQ-010 Port done, output, 1: one-cycle completion pulse.
REQ-011 Port result, output, W: sum or difference.
REQ-012 Port carry_out, output, 1: carry out of bit W-1; for subtract, 1 = no borrow.
REQ-013 Port overflow, output, 1: two's-complement signed overflow.
REQ-014 Port zero, output, 1: result equals 0.

Function
REQ-015 The block SHALL contain exactly one N-bit combinational slice computing {cu,s} = x + (k ? ~y : y) + ci, with k driven from the latched op.
REQ-016 The FSM SHALL have two states: IDLE and RUN.
REQ-017 In IDLE with start=1 at an edge (E0), the block SHALL latch a, b and op, clear the slice index to 0, load the carry register with op, and enter RUN.
REQ-018 Busy SHALL be high from E0 until the edge that writes the last slice.
REQ-019 In RUN at edge E(i+1), for i = 0..WORDS-1, the block SHALL apply to the slice: x = latched a[i*N +: N], y = latched b[i*N +: N], ci = carry register.
REQ-020 At that edge, result[i*N +: N] SHALL take s and the carry register SHALL take cu.
REQ-021 Slice order SHALL be LSB slice first; the index SHALL increment by 1 per cycle with no skipped or repeated slices.
REQ-022 At edge E(WORDS), the block SHALL write the last slice and update carry_out, overflow and zero, assert done, clear busy and return to IDLE.
REQ-023 Start-to-done latency SHALL be exactly WORDS cycles.
REQ-024 Done SHALL be high for exactly one cycle per operation.
REQ-025 Overflow SHALL equal (a[W-1] == y'[W-1]) AND (result[W-1] != a[W-1]), where y' = op ? ~b : b.
REQ-026 Zero SHALL equal (result == 0) over the final result.
REQ-027 Result, carry_out, overflow and zero SHALL hold their values from completion until the next operation's first write.
REQ-028 Intermediate result bits MAY be visible while busy=1 and are valid only when done=1 or later in IDLE.
REQ-029 Start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-030 Changes on a, b or op while busy=1 SHALL NOT affect the running operation.
REQ-031 Start held high continuously SHALL begin a new operation on the edge after done, i.e. back-to-back operations every WORDS+1 cycles.

Reset
REQ-032 When rst_n=0, state SHALL be IDLE, and busy, done, carry_out and overflow SHALL be 0.
REQ-033 When rst_n=0, result SHALL be 0 and zero SHALL be 1, consistent with result=0.
REQ-034 Reset asserted mid-operation SHALL abort immediately and asynchronously; no done pulse SHALL follow for the aborted operation.
REQ-035 After rst_n rises, the first edge with start=1 SHALL begin a fresh operation.

Verification
REQ-036 Add: a=0x00FF, b=0x0001, op=0 -> done 4 cycles after start; result=0x0100, carry_out=0, overflow=0, zero=0.
REQ-037 Subtract, equal operands: a=0x0005, b=0x0005, op=1 -> result=0x0000, carry_out=1, overflow=0, zero=1.
REQ-038 Signed overflow: a=0x7FFF, b=0x0001, op=0 -> result=0x8000, carry_out=0, overflow=1, zero=0.
REQ-039 Wrap and borrow: a=0xFFFF, b=0x0001, op=0 -> result=0x0000, carry_out=1, overflow=0, zero=1. Then a=0x0000, b=0x0001, op=1 -> result=0xFFFF, carry_out=0, overflow=0.
REQ-040 Start pulsed at cycle 2 of a running operation -> ignored; exactly one done; busy low for one cycle before the next accepted start.
REQ-041 Reset mid-operation: rst_n=0 at cycle 2 of an operation -> busy=0, result=0, zero=1 immediately; no done pulse; the next operation is correct.
